uart_boot_loader: RTL and testbench

- Sequencer that drains the UART receive FIFO and loads a Hack program into instruction ROM.
- Parses a framed byte stream, assembles 16-bit words big-endian, writes them to consecutive ROM addresses and verifies an 8-bit checksum.
- Holds the CPU in reset while loading and releases it only after a good load.
- Sits between the UART (FIFO side) and the ROM write port / CPU reset in the top level.

---
 rtl/uart_boot_loader_pkg.sv | 30 +++
 rtl/loader_timeout_timer.sv | 37 +++
 rtl/uart_boot_loader.sv | 163 ++++++++++++++++
 tb/tb_uart_boot_loader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_boot_loader_pkg.sv
// Shared definitions for the UART boot loader: FSM state encodings and default framing constants.
package uart_boot_loader_pkg;

    localparam int unsigned STATE_W = 4;

    localparam logic [3:0] ST_SYNC    = 4'd0;
    localparam logic [3:0] ST_LEN_HI  = 4'd1;
    localparam logic [3:0] ST_LEN_LO  = 4'd2;
    localparam logic [3:0] ST_DATA_HI = 4'd3;
    localparam logic [3:0] ST_DATA_LO = 4'd4;
    localparam logic [3:0] ST_WRITE   = 4'd5;
    localparam logic [3:0] ST_CHECK   = 4'd6;
    localparam logic [3:0] ST_DONE    = 4'd7;
    localparam logic [3:0] ST_ERROR   = 4'd8;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // States that pop one FIFO byte per cycle whenever the FIFO is non-empty.
    function automatic logic is_byte_state(input logic [3:0] s);
        return (s == ST_SYNC) || (s == ST_LEN_HI) || (s == ST_LEN_LO) ||
               (s == ST_DATA_HI) || (s == ST_DATA_LO) || (s == ST_CHECK);
    endfunction

    // States in which an idle FIFO is counted toward the inter-byte timeout.
    function automatic logic is_timed_state(input logic [3:0] s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) ||
               (s == ST_DATA_LO) || (s == ST_WRITE) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/loader_timeout_timer.sv
// Idle-cycle counter for the boot loader; clears on every byte pop and flags the terminal count.
module loader_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic i_CLK,
    input  logic i_RESET_n,
    input  logic i_Clear,
    input  logic i_Enable,
    output logic o_Terminal
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_Clear) begin
            count_d = '0;
        end else if (i_Enable && (count_q != LAST)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_Terminal = (count_q == LAST);

endmodule

// File: rtl/uart_boot_loader.sv
// Drains the UART RX FIFO, parses a SYNC/LEN/data/CHK frame into instruction ROM,
// and holds the CPU in reset until a load completes with a matching checksum.
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int unsigned ADDR_BITS      = 15,
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                 i_CLK,
    input  logic                 i_RESET_n,
    input  logic                 i_Start,
    input  logic                 i_UART_Empty,
    input  logic [7:0]           i_UART_Data,
    output logic                 o_UART_Read_EN,
    output logic                 o_ROM_Write_EN,
    output logic [ADDR_BITS-1:0] o_ROM_Addr,
    output logic [15:0]          o_ROM_Data,
    output logic                 o_CPU_Reset_n,
    output logic                 o_Busy,
    output logic                 o_Error
);

    logic [STATE_W-1:0]   state_q,     state_d;
    logic [ADDR_BITS-1:0] addr_q,      addr_d;
    logic [15:0]          remaining_q, remaining_d;
    logic [7:0]           len_hi_q,    len_hi_d;
    logic [7:0]           data_hi_q,   data_hi_d;
    logic [7:0]           data_lo_q,   data_lo_d;
    logic [7:0]           chk_q,       chk_d;

    logic        pop;
    logic        timed;
    logic        timer_tc;
    logic [15:0] len_full;
    logic        len_too_long;

    assign pop      = is_byte_state(state_q) && !i_UART_Empty;
    assign timed    = is_timed_state(state_q);
    assign len_full = {len_hi_q, i_UART_Data};
    // Widened compare so the 2^ADDR_BITS limit itself stays representable.
    assign len_too_long = ({17'd0, len_full} > (33'd1 << ADDR_BITS));

    // WRITE holds the timer rather than counting, since no pop is possible there.
    loader_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .i_CLK      (i_CLK),
        .i_RESET_n  (i_RESET_n),
        .i_Clear    (pop || !timed),
        .i_Enable   (timed && (state_q != ST_WRITE)),
        .o_Terminal (timer_tc)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        len_hi_d    = len_hi_q;
        data_hi_d   = data_hi_q;
        data_lo_d   = data_lo_q;
        chk_d       = chk_q;

        case (state_q)
            ST_SYNC: begin
                if (!i_UART_Empty && (i_UART_Data == SYNC_BYTE)) begin
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (!i_UART_Empty) begin
                    len_hi_d = i_UART_Data;
                    state_d  = ST_LEN_LO;
                end else if (timer_tc) begin
                    state_d = ST_ERROR;
                end
            end
            ST_LEN_LO: begin
                if (!i_UART_Empty) begin
                    addr_d      = '0;
                    chk_d       = '0;
                    remaining_d = len_full;
                    if (len_full == 16'd0) begin
                        state_d = ST_CHECK;
                    end else if (len_too_long) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end else if (timer_tc) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DATA_HI: begin
                if (!i_UART_Empty) begin
                    data_hi_d = i_UART_Data;
                    chk_d     = chk_q + i_UART_Data;
                    state_d   = ST_DATA_LO;
                end else if (timer_tc) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DATA_LO: begin
                if (!i_UART_Empty) begin
                    data_lo_d = i_UART_Data;
                    chk_d     = chk_q + i_UART_Data;
                    state_d   = ST_WRITE;
                end else if (timer_tc) begin
                    state_d = ST_ERROR;
                end
            end
            ST_WRITE: begin
                addr_d      = addr_q + ADDR_BITS'(1);
                remaining_d = remaining_q - 16'd1;
                state_d     = (remaining_q == 16'd1) ? ST_CHECK : ST_DATA_HI;
            end
            ST_CHECK: begin
                if (!i_UART_Empty) begin
                    state_d = (i_UART_Data == chk_q) ? ST_DONE : ST_ERROR;
                end else if (timer_tc) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (i_Start) begin
                    state_d = ST_SYNC;
                end
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            state_q     <= ST_SYNC;
            addr_q      <= '0;
            remaining_q <= '0;
            len_hi_q    <= '0;
            data_hi_q   <= '0;
            data_lo_q   <= '0;
            chk_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            len_hi_q    <= len_hi_d;
            data_hi_q   <= data_hi_d;
            data_lo_q   <= data_lo_d;
            chk_q       <= chk_d;
        end
    end

    assign o_UART_Read_EN = pop;
    assign o_ROM_Write_EN = (state_q == ST_WRITE);
    assign o_ROM_Addr     = addr_q;
    assign o_ROM_Data     = {data_hi_q, data_lo_q};
    assign o_CPU_Reset_n  = (state_q == ST_DONE);
    assign o_Busy         = (state_q != ST_DONE) && (state_q != ST_ERROR);
    assign o_Error        = (state_q == ST_ERROR);

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed self-checking bench for uart_boot_loader with a show-ahead FIFO model and ROM write log.
module tb_uart_boot_loader;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        uart_empty;
    logic [7:0]  uart_data;
    logic        rd_en;
    logic        we;
    logic [14:0] addr;
    logic [15:0] data;
    logic        cpu_rst_n;
    logic        busy;
    logic        err;

    logic [7:0]  fifo_mem [0:1023];
    int          fifo_wr = 0;
    int          fifo_rd = 0;
    logic [14:0] wr_addr_log [0:63];
    logic [15:0] wr_data_log [0:63];
    int          n_writes = 0;
    int          rd_violations = 0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign uart_empty = (fifo_rd == fifo_wr);
    assign uart_data  = fifo_mem[fifo_rd[9:0]];

    always @(posedge clk) begin
        if (rd_en && uart_empty) rd_violations <= rd_violations + 1;
        if (rd_en && !uart_empty) fifo_rd <= fifo_rd + 1;
        if (we) begin
            wr_addr_log[n_writes[5:0]] <= addr;
            wr_data_log[n_writes[5:0]] <= data;
            n_writes <= n_writes + 1;
        end
    end

    uart_boot_loader #(
        .ADDR_BITS(15),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .i_CLK          (clk),
        .i_RESET_n      (rst_n),
        .i_Start        (start),
        .i_UART_Empty   (uart_empty),
        .i_UART_Data    (uart_data),
        .o_UART_Read_EN (rd_en),
        .o_ROM_Write_EN (we),
        .o_ROM_Addr     (addr),
        .o_ROM_Data     (data),
        .o_CPU_Reset_n  (cpu_rst_n),
        .o_Busy         (busy),
        .o_Error        (err)
    );

    task automatic push(input logic [7:0] b);
        fifo_mem[fifo_wr[9:0]] = b;
        fifo_wr = fifo_wr + 1;
    endtask

    task automatic push_vec(input logic [127:0] v, input int n);
        for (int i = 0; i < n; i++) push(v[8*(n-1-i) +: 8]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        start   = 1'b0;
        fifo_wr = fifo_rd;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int cycles, output bit ok);
        ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (cpu_rst_n !== 1'b0) begin bad++; $display("FAIL reset_cpu_rst_n: got %b want 0", cpu_rst_n); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b want 1", busy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", err); end
        total++; if (we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", we); end
        total++; if (addr !== 15'd0) begin bad++; $display("FAIL reset_addr: got %h want 0", addr); end
        total++; if (data !== 16'd0) begin bad++; $display("FAIL reset_data: got %h want 0", data); end
        total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL idle_sync_busy: got %b want 1", busy); end
    endtask

    task automatic test_good_frame();
        int base, cyc;
        bit ok;
        do_reset();
        base = n_writes;
        @(negedge clk);
        push_vec(128'hA5_00_02_12_34_AB_CD_BE, 8);
        wait_idle(50, cyc, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL good_done_timeout: got busy=%b want 0", busy); end
        total++; if (cyc != 10) begin bad++; $display("FAIL good_frame_cycles: got %0d want 10", cyc); end
        total++; if (n_writes - base != 2) begin bad++; $display("FAIL good_nwrites: got %0d want 2", n_writes - base); end
        total++; if (wr_addr_log[base[5:0]] !== 15'd0) begin bad++; $display("FAIL good_w0_addr: got %h want 0", wr_addr_log[base[5:0]]); end
        total++; if (wr_data_log[base[5:0]] !== 16'h1234) begin bad++; $display("FAIL good_w0_data: got %h want 1234", wr_data_log[base[5:0]]); end
        total++; if (wr_addr_log[(base + 1) % 64] !== 15'd1) begin bad++; $display("FAIL good_w1_addr: got %h want 1", wr_addr_log[(base + 1) % 64]); end
        total++; if (wr_data_log[(base + 1) % 64] !== 16'hABCD) begin bad++; $display("FAIL good_w1_data: got %h want abcd", wr_data_log[(base + 1) % 64]); end
        total++; if (cpu_rst_n !== 1'b1) begin bad++; $display("FAIL good_cpu_rst_n: got %b want 1", cpu_rst_n); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL good_error: got %b want 0", err); end
    endtask

    task automatic test_bad_checksum();
        int base, cyc;
        bit ok;
        do_reset();
        base = n_writes;
        @(negedge clk);
        push_vec(128'hA5_00_02_12_34_AB_CD_6D, 8);
        wait_idle(50, cyc, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL badchk_idle_timeout: got busy=%b want 0", busy); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL badchk_error: got %b want 1", err); end
        total++; if (cpu_rst_n !== 1'b0) begin bad++; $display("FAIL badchk_cpu_rst_n: got %b want 0", cpu_rst_n); end
        total++; if (n_writes - base != 2) begin bad++; $display("FAIL badchk_nwrites: got %0d want 2", n_writes - base); end
        pulse_start();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL restart_busy: got %b want 1", busy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL restart_error: got %b want 0", err); end
        base = n_writes;
        push_vec(128'hA5_00_01_00_07_07, 6);
        wait_idle(50, cyc, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL reload_timeout: got busy=%b want 0", busy); end
        total++; if (err !== 1'b0 || cpu_rst_n !== 1'b1) begin bad++; $display("FAIL reload_done: got err=%b cpu_rst_n=%b want 0/1", err, cpu_rst_n); end
        total++; if (n_writes - base != 1 || wr_data_log[base[5:0]] !== 16'h0007) begin bad++; $display("FAIL reload_write: got n=%0d data=%h want 1/0007", n_writes - base, wr_data_log[base[5:0]]); end
    endtask

    task automatic test_garbage();
        int base, cyc;
        bit ok;
        pulse_start();
        base = n_writes;
        push_vec(128'h00_FF_5A_A5_00_01_00_07_07, 9);
        wait_idle(50, cyc, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL garbage_timeout: got busy=%b want 0", busy); end
        total++; if (cyc != 10) begin bad++; $display("FAIL garbage_cycles: got %0d want 10", cyc); end
        total++; if (n_writes - base != 1) begin bad++; $display("FAIL garbage_nwrites: got %0d want 1", n_writes - base); end
        total++; if (wr_addr_log[base[5:0]] !== 15'd0) begin bad++; $display("FAIL garbage_addr: got %h want 0", wr_addr_log[base[5:0]]); end
        total++; if (wr_data_log[base[5:0]] !== 16'h0007) begin bad++; $display("FAIL garbage_data: got %h want 0007", wr_data_log[base[5:0]]); end
        total++; if (cpu_rst_n !== 1'b1) begin bad++; $display("FAIL garbage_cpu_rst_n: got %b want 1", cpu_rst_n); end
    endtask

    task automatic test_start_ignored();
        int base, cyc;
        bit ok;
        do_reset();
        base = n_writes;
        @(negedge clk);
        push_vec(128'hA5_00_01, 3);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        push_vec(128'h12_34_46, 3);
        wait_idle(50, cyc, ok);
        total++; if (ok !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL busy_start_done: got ok=%b err=%b want 1/0", ok, err); end
        total++; if (n_writes - base != 1 || wr_data_log[base[5:0]] !== 16'h1234) begin bad++; $display("FAIL busy_start_write: got n=%0d data=%h want 1/1234", n_writes - base, wr_data_log[base[5:0]]); end
    endtask

    task automatic test_zero_len();
        int base, cyc;
        bit ok;
        pulse_start();
        total++; if (cpu_rst_n !== 1'b0) begin bad++; $display("FAIL zero_restart_cpu_rst_n: got %b want 0", cpu_rst_n); end
        base = n_writes;
        push_vec(128'hA5_00_00_00, 4);
        wait_idle(50, cyc, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL zero_timeout: got busy=%b want 0", busy); end
        total++; if (n_writes != base) begin bad++; $display("FAIL zero_nwrites: got %0d want 0", n_writes - base); end
        total++; if (cpu_rst_n !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL zero_done: got cpu_rst_n=%b err=%b want 1/0", cpu_rst_n, err); end
    endtask

    task automatic test_too_long();
        int base, cyc;
        bit ok;
        pulse_start();
        base = n_writes;
        push_vec(128'hA5_80_01, 3);
        wait_idle(50, cyc, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL toolong_timeout: got busy=%b want 0", busy); end
        total++; if (cyc != 3) begin bad++; $display("FAIL toolong_cycles: got %0d want 3", cyc); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL toolong_error: got %b want 1", err); end
        total++; if (n_writes != base) begin bad++; $display("FAIL toolong_nwrites: got %0d want 0", n_writes - base); end
    endtask

    task automatic test_timeout();
        int base, n;
        do_reset();
        base = n_writes;
        n = 0;
        @(negedge clk);
        push_vec(128'hA5_00_01_12, 4);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (err) break;
        end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL timeout_error: got %b want 1", err); end
        total++; if (n != 104) begin bad++; $display("FAIL timeout_cycles: got %0d want 104", n); end
        total++; if (cpu_rst_n !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL timeout_outputs: got cpu_rst_n=%b busy=%b want 0/0", cpu_rst_n, busy); end
        total++; if (n_writes != base) begin bad++; $display("FAIL timeout_nwrites: got %0d want 0", n_writes - base); end
        total++; if (rd_violations != 0) begin bad++; $display("FAIL read_while_empty: got %0d want 0", rd_violations); end
    endtask

    task automatic test_async_reset();
        int base, cyc;
        bit ok;
        do_reset();
        base = n_writes;
        @(negedge clk);
        push_vec(128'hA5_00_02_12_34_AB_CD_BE, 8);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (n_writes > base) break;
        end
        total++; if (n_writes - base != 1 || wr_data_log[base[5:0]] !== 16'h1234) begin bad++; $display("FAIL midload_first_write: got n=%0d data=%h want 1/1234", n_writes - base, wr_data_log[base[5:0]]); end
        #2;
        fifo_wr = fifo_rd;
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b1 || cpu_rst_n !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL areset_status: got busy=%b cpu_rst_n=%b err=%b want 1/0/0", busy, cpu_rst_n, err); end
        total++; if (we !== 1'b0 || rd_en !== 1'b0) begin bad++; $display("FAIL areset_strobes: got we=%b rd_en=%b want 0/0", we, rd_en); end
        total++; if (addr !== 15'd0) begin bad++; $display("FAIL areset_addr: got %h want 0", addr); end
        total++; if (data !== 16'd0) begin bad++; $display("FAIL areset_data: got %h want 0", data); end
        @(negedge clk);
        rst_n = 1'b1;
        base = n_writes;
        @(negedge clk);
        push_vec(128'hA5_00_01_BE_EF_AD, 6);
        wait_idle(50, cyc, ok);
        total++; if (ok !== 1'b1 || cpu_rst_n !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL postreset_done: got ok=%b cpu_rst_n=%b err=%b want 1/1/0", ok, cpu_rst_n, err); end
        total++; if (n_writes - base != 1 || wr_addr_log[base[5:0]] !== 15'd0 || wr_data_log[base[5:0]] !== 16'hBEEF) begin bad++; $display("FAIL postreset_write: got n=%0d addr=%h data=%h want 1/0/beef", n_writes - base, wr_addr_log[base[5:0]], wr_data_log[base[5:0]]); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_garbage();
        test_start_ignored();
        test_zero_len();
        test_too_long();
        test_timeout();
        test_async_reset();
        total++; if (rd_violations != 0) begin bad++; $display("FAIL read_while_empty_total: got %0d want 0", rd_violations); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
